if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline.
- Holds the PC and the debug-loadable instruction memory.
- Selects the next PC: sequential, branch, jump or jump-register.
- Detects the HALT word and raises the sticky end-of-program flag.
- Feeds the IF/ID register with instruction, PC+4 and PC_end. Exposes PC and counters to the debug unit.

Parameters:
- MEM_DEPTH, 256, instruction memory depth in 32-bit words.
- ADDR_W, 8, word-address width; equals log2(MEM_DEPTH).
- RESET_PC, 32'h0000_0000, PC value after reset.
- HALT_INST, 32'hFFFF_FFFF, encoding that ends execution.

Ports:
- clk  in  1  single clock, posedge.
- reset  in  1  synchronous, active-high.
- db_ena  in  1  debug-unit clock enable; 0 freezes PC, FSM and counters.
- PC_Wr  in  1  from hazard unit; 0 holds PC (stall).
- PCSrc  in  2  00 = PC+4, 01 = branch_target, 10 = jump_target, 11 = jr_target.
- branch_target  in  32  branch address from ID.
- jump_target  in  32  jump address from ID.
- jr_target  in  32  register jump address from ID.
- db_wr_en  in  1  program-load write strobe.
- db_wr_addr  in  ADDR_W  program-load word address.
- db_wr_data  in  32  program-load word.
- out_PC  out  32  current PC.
- out_inst  out  32  instruction at current PC.
- out_PCnext  out  32  current PC + 4.
- PC_end  out  1  sticky halt flag.
- cycle_count  out  32  enabled cycles in RUN.
- fetch_count  out  32  PC advances performed.

Behaviour:
- Clocking: clk only; reset is sampled on posedge clk, and reset has priority over every other input.
- Reset state: PC=RESET_PC, FSM=RUN, PC_end=0, cycle_count=0, fetch_count=0.
- Reset does not clear instruction memory. Memory initialises to all zeros (NOP) at simulation start.
- Memory write: on posedge with db_wr_en=1, mem[db_wr_addr] <= db_wr_data.
  - The write is independent of db_ena, FSM state and reset.
- Memory read: asynchronous, index = PC[ADDR_W+1:2]. Same-cycle write to the current index: out_inst shows old data before the edge and new data after it.
- Out of range: if PC[31:ADDR_W+2] != 0, out_inst = HALT_INST.
- out_PCnext = PC + 4, combinational, wraps mod 2^32 (32'hFFFF_FFFC -> 0).
- PC update at posedge when db_ena && PC_Wr && state==RUN:
  - PCSrc selects PC+4 or the matching target.
  - Bits [1:0] of the new PC are forced to 00.
  - fetch_count increments.
- PC hold: PC_Wr=0 holds PC whatever PCSrc is; the hazard unit guarantees stall and redirect never conflict. db_ena=0 or state HALTED also holds PC.
- FSM RUN -> HALTED at posedge when all hold:
  - db_ena=1
  - PC_Wr=1
  - out_inst==HALT_INST
  - PCSrc==00 (a halt word fetched in the shadow of a redirect is discarded and does not halt)
- On that edge the PC does not advance and fetch_count does not increment.
- HALTED: PC_end=1 registered, PC and counters frozen. The state is left only via reset.
- PC_end is a direct decode of the state, so it rises the cycle after the HALT word is presented. The HALT word itself is therefore captured into IF/ID, and all later captures are blocked.
- cycle_count increments every posedge with db_ena=1 and state RUN, including stalled cycles.
- Counters wrap mod 2^32.
- Reset mid-run: the next edge returns to the reset state and loaded program is retained.

Test Plan:
- Load mem[0..3]=0x11,0x22,0x33,HALT via db_wr_*, reset, db_ena=1, PC_Wr=1, PCSrc=00 -> out_inst 0x11,0x22,0x33 on successive cycles, out_PCnext 4,8,C. PC_end=1 one cycle after PC=0xC; PC stays 0xC; fetch_count=3.
- PC=8, PC_Wr=0 for 3 cycles -> PC stays 8, fetch_count unchanged, cycle_count +3. Release -> PC=0xC.
- PC=4 with PCSrc=01, branch_target=0x41 -> next PC=0x40. Same check for PCSrc=10 (jump) and PCSrc=11 (jr).
- HALT at PC=8 with PCSrc=10, jump_target=0x20 -> no halt, PC=0x20, PC_end stays 0.
- db_ena=0 for 5 cycles mid-run -> PC, counters and FSM unchanged. A db_wr_en write during this window still lands in memory.
- After halt, assert reset one cycle -> PC=0, PC_end=0, counters 0, program intact and re-executes identically. Separately, PC=0x400 (out of range, ADDR_W=8) -> out_inst=HALT_INST and halts.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, debug-loadable instruction memory,
// next-PC selection, HALT detection and run counters for the debug unit.
module if_stage #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_INST = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              db_ena,
  input  logic              PC_Wr,
  input  logic [1:0]        PCSrc,
  input  logic [31:0]       branch_target,
  input  logic [31:0]       jump_target,
  input  logic [31:0]       jr_target,
  input  logic              db_wr_en,
  input  logic [ADDR_W-1:0] db_wr_addr,
  input  logic [31:0]       db_wr_data,
  output logic [31:0]       out_PC,
  output logic [31:0]       out_inst,
  output logic [31:0]       out_PCnext,
  output logic              PC_end,
  output logic [31:0]       cycle_count,
  output logic [31:0]       fetch_count
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t            state;
  logic [31:0]       pc;
  logic [31:0]       mem [MEM_DEPTH] = '{default: '0};
  logic [ADDR_W-1:0] rd_idx;
  logic              in_range;
  logic [31:0]       pc_plus4;
  logic [31:0]       pc_sel;
  logic              fetch_en;
  logic              halt_hit;

  // Program load port; independent of run state and reset.
  always_ff @(posedge clk) begin
    if (db_wr_en) begin
      mem[db_wr_addr] <= db_wr_data;
    end
  end

  assign rd_idx     = pc[ADDR_W+1:2];
  assign in_range   = (pc[31:ADDR_W+2] == '0);
  assign out_inst   = in_range ? mem[rd_idx] : HALT_INST;
  assign pc_plus4   = pc + 32'd4;
  assign out_PCnext = pc_plus4;
  assign out_PC     = pc;

  always_comb begin
    pc_sel = pc_plus4;
    unique case (PCSrc)
      2'b00:   pc_sel = pc_plus4;
      2'b01:   pc_sel = branch_target;
      2'b10:   pc_sel = jump_target;
      default: pc_sel = jr_target;
    endcase
  end

  assign fetch_en = db_ena && (state == ST_RUN);
  // A HALT word only stops the machine when it is on the sequential path.
  assign halt_hit = fetch_en && PC_Wr && (out_inst == HALT_INST) && (PCSrc == 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      state       <= ST_RUN;
      PC_end      <= 1'b0;
      cycle_count <= '0;
      fetch_count <= '0;
    end else if (fetch_en) begin
      cycle_count <= cycle_count + 32'd1;
      if (halt_hit) begin
        state  <= ST_HALTED;
        PC_end <= 1'b1;
      end else if (PC_Wr) begin
        pc          <= {pc_sel[31:2], 2'b00};
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule
